// File: rtl/vldrdy_frame_arbiter.sv
// Two-input round-robin arbiter for a valid/ready stream.
// Grants are locked for FRAME_LEN beats and re-arbitrated only between frames.
module vldrdy_frame_arbiter #(
    parameter int DATAW     = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [DATAW-1:0] s0_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [DATAW-1:0] s1_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DATAW-1:0] m_data,
    output logic             m_src,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic          grant;
    logic          last;
    logic [CW-1:0] cnt;

    logic any_req;
    logic winner;
    logic beat;
    logic final_beat;

    assign any_req = s0_valid | s1_valid;
    // On a tie the requester not served last time wins.
    assign winner  = (s0_valid & s1_valid) ? ~last : s1_valid;

    assign busy     = (state == BUSY);
    assign m_src    = grant;
    assign m_valid  = busy & (grant ? s1_valid : s0_valid);
    assign m_data   = busy ? (grant ? s1_data : s0_data) : '0;
    assign s0_ready = busy & ~grant & m_ready;
    assign s1_ready = busy & grant & m_ready;

    assign beat       = m_valid & m_ready;
    assign final_beat = beat & (cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_en && any_req) begin
                        state <= BUSY;
                        grant <= winner;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (final_beat) begin
                        state      <= IDLE;
                        last       <= grant;
                        cnt        <= '0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vldrdy_frame_arbiter.sv
// Scoreboard bench for vldrdy_frame_arbiter with FRAME_LEN=4.
// Producers feed queued words; a negedge monitor checks every beat.
module tb_vldrdy_frame_arbiter;

    localparam int DW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic          s0_valid;
    logic          s0_ready;
    logic [DW-1:0] s0_data;
    logic          s1_valid;
    logic          s1_ready;
    logic [DW-1:0] s1_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_src;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    typedef struct {
        logic        src;
        logic [15:0] data;
        int          gap;
        int          at;
    } exp_t;

    exp_t        q_exp[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int beats     = 0;
    int done_seen = 0;
    int prev_beat = 0;

    vldrdy_frame_arbiter #(.DATAW(DW), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_data    (s0_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_data    (s1_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_src      (m_src),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic src, input logic [15:0] d,
                        input int gap, input int at);
        exp_t e;
        e.src  = src;
        e.data = d;
        e.gap  = gap;
        e.at   = at;
        q_exp.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        bool_loop: for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q_exp.size() == 0 && !busy) begin
                repeat (2) @(negedge clk);
                #1;
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int b0;
        b0 = beats;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #3;
            if (beats >= b0 + n) return;
        end
        chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Producer model: hold each word until its handshake completes.
    initial begin
        logic h0;
        logic h1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = '0;
        s1_data  = '0;
        forever begin
            @(negedge clk);
            h0 = s0_valid & s0_ready;
            h1 = s1_valid & s1_ready;
            @(posedge clk);
            #1;
            if (h0 && q0.size() > 0) void'(q0.pop_front());
            if (h1 && q1.size() > 0) void'(q1.pop_front());
            s0_valid = (q0.size() > 0);
            s1_valid = (q1.size() > 0);
            s0_data  = s0_valid ? q0[0] : '0;
            s1_data  = s1_valid ? q1[0] : '0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_done) begin
                done_seen++;
                chk("done_in_idle", 32'(busy), 32'd0);
            end
            if (!busy)
                chk("idle_out", 32'({m_valid, s0_ready, s1_ready, m_data}), 32'd0);
            else
                chk("ready_route", 32'({s0_ready, s1_ready}),
                    m_src ? 32'({1'b0, m_ready}) : 32'({m_ready, 1'b0}));
            if (m_valid && m_ready) begin
                beats++;
                if (q_exp.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data), 32'hffff_ffff);
                end else begin
                    e = q_exp.pop_front();
                    chk("data", 32'(m_data), 32'(e.data));
                    chk("src", 32'(m_src), 32'(e.src));
                    if (e.gap > 0) chk("gap", 32'(cyc + 1 - prev_beat), 32'(e.gap));
                    if (e.at >= 0) chk("latency", 32'(cyc + 1), 32'(e.at));
                end
                prev_beat = cyc + 1;
            end
        end
    end

    initial begin
        int c;
        rst_n   = 1'b0;
        cfg_en  = 1'b1;
        m_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'({m_valid, s0_ready, s1_ready, m_src, frame_done}), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tie: s0, s1, s0 with one dead cycle between frames.
        @(negedge clk);
        for (int i = 1; i <= 8; i++) q0.push_back(16'(16'h0100 + i));
        for (int i = 1; i <= 4; i++) q1.push_back(16'(16'h0200 + i));
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 4; b++)
                push(f == 1,
                     (f == 1) ? 16'(16'h0201 + b) : 16'(16'h0101 + 4 * (f / 2) + b),
                     (b != 0) ? 1 : ((f == 0) ? 0 : 2), -1);
        wait_done("tie");
        chk("tie_cnt", 32'(frame_cnt), 32'd3);
        chk("tie_done", 32'(done_seen), 32'd3);

        // Single requester and arbitration latency.
        @(negedge clk);
        c = cyc;
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(16'(i));
            push(1'b0, 16'(i), (i == 1) ? 0 : 1, (i == 1) ? c + 3 : -1);
        end
        wait_done("single");
        chk("single_cnt", 32'(frame_cnt), 32'd4);
        chk("single_done", 32'(done_seen), 32'd4);
        chk("single_busy", 32'(busy), 32'd0);

        // Backpressure on an s1 frame.
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            q1.push_back(16'(16'h0300 + i));
            push(1'b1, 16'(16'h0300 + i), (i == 1) ? 0 : 2, -1);
        end
        for (int i = 0; i < 60 && !(q_exp.size() == 0 && !busy); i++) begin
            @(posedge clk);
            #2;
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        wait_done("bp");
        chk("bp_cnt", 32'(frame_cnt), 32'd5);

        // Disabled arbiter ignores requests, then a frame outlives cfg_en.
        @(negedge clk);
        cfg_en = 1'b0;
        for (int i = 1; i <= 4; i++) q0.push_back(16'(16'h0400 + i));
        for (int i = 1; i <= 4; i++) q1.push_back(16'(16'h0500 + i));
        repeat (6) @(negedge clk);
        #1;
        chk("cfg_off_busy", 32'(busy), 32'd0);
        chk("cfg_off_valid", 32'(m_valid), 32'd0);
        for (int i = 1; i <= 4; i++)
            push(1'b0, 16'(16'h0400 + i), (i == 1) ? 0 : 1, -1);
        cfg_en = 1'b1;
        wait_beats(2, "cfg_beats");
        cfg_en = 1'b0;
        wait_done("cfg");
        repeat (4) @(negedge clk);
        #1;
        chk("cfg_stay_idle", 32'(busy), 32'd0);
        chk("cfg_cnt", 32'(frame_cnt), 32'd6);
        chk("cfg_done", 32'(done_seen), 32'd6);
        q1.delete();
        repeat (3) @(negedge clk);
        cfg_en = 1'b1;

        // Asynchronous reset in the middle of an s1 frame.
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            q1.push_back(16'(16'h0600 + i));
            push(1'b1, 16'(16'h0600 + i), (i == 1) ? 0 : 1, -1);
        end
        wait_beats(2, "rst_beats");
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out", 32'({m_valid, s0_ready, s1_ready, m_src, frame_done}), 32'd0);
        chk("arst_data", 32'(m_data), 32'd0);
        chk("arst_cnt", 32'(frame_cnt), 32'd0);
        q1.delete();
        q_exp.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        for (int i = 1; i <= 4; i++) q0.push_back(16'(16'h0700 + i));
        for (int i = 1; i <= 4; i++) q1.push_back(16'(16'h0800 + i));
        for (int i = 1; i <= 4; i++)
            push(1'b0, 16'(16'h0700 + i), (i == 1) ? 0 : 1, -1);
        for (int i = 1; i <= 4; i++)
            push(1'b1, 16'(16'h0800 + i), (i == 1) ? 2 : 1, -1);
        wait_done("post_rst");
        chk("post_rst_cnt", 32'(frame_cnt), 32'd2);
        chk("post_rst_done", 32'(done_seen), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vldrdy_frame_arbiter.md
# vldrdy_frame_arbiter

Two-input frame-locked round-robin arbiter for the output valid/ready stream. Two producers (for example, two datapath lanes) share the single output stream feeding the output sink/dump port. Arbitration happens only on frame boundaries: once a requester is granted, exactly FRAME_LEN beats pass from it before the arbiter re-arbitrates. Enable is gated by cfg_en; frame completion is reported by a pulse and a wrapping frame counter.

## Interface
- DATAW, 16, data width of every stream (8 or 16 used in the design)
- FRAME_LEN, 64, beats per frame; legal range 2..65535
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous reset, active-low
- cfg_en  input  1  arbitration enable; sampled only in IDLE
- s0_valid  input  1  requester 0 valid
- s0_ready  output  1  requester 0 ready
- s0_data  input  DATAW  requester 0 data
- s1_valid  input  1  requester 1 valid
- s1_ready  output  1  requester 1 ready
- s1_data  input  DATAW  requester 1 data
- m_valid  output  1  output stream valid
- m_ready  input  1  output stream ready
- m_data  output  DATAW  output stream data
- m_src  output  1  index of currently granted requester
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse, frame completed
- frame_cnt  output  16  completed frames, wraps 0xFFFF->0

## Operation
- State machine with two states, IDLE and BUSY, plus registers: grant (1 bit), last (1 bit), beat counter of width $clog2(FRAME_LEN).
- IDLE:
  - If cfg_en=1 and any s*_valid=1, pick the winner and go to BUSY next cycle.
  - The winner is the only valid requester; if both are valid, the winner is !last.
  - Load grant with the winner and clear the beat counter.
  - If cfg_en=0, or neither requester is valid, stay in IDLE.
- BUSY:
  - m_valid = s[grant]_valid; m_data = s[grant]_data; s[grant]_ready = m_ready.
  - The non-granted requester's ready = 0.
  - Paths are combinational; no data is registered.
- Beat: m_valid & m_ready in BUSY. Each beat increments the counter.
- Final beat (counter = FRAME_LEN-1): next state is IDLE, last <= grant, frame_done=1 for one cycle, frame_cnt+1.
- IDLE outputs: m_valid=0, both readies=0, m_data=0.
- cfg_en deasserted during BUSY: the current frame completes normally and no new grant follows.
- A requester dropping valid mid-frame stalls the frame (m_valid=0). The grant holds and there is no timeout.
- m_src = grant; it holds its value in IDLE.

## Timing
- Reset values: state IDLE, grant=0, last=1 (s0 wins the first tie), counter=0, m_valid=0, s0_ready=0, s1_ready=0, m_data=0, m_src=0, busy=0, frame_done=0, frame_cnt=0.
- Arbitration latency: a request seen in IDLE at edge N gives busy=1 and passes the first beat from edge N+1 onward.
- Back-to-back frames: after the final beat at edge N, IDLE occupies cycle N..N+1. The next frame starts at N+2, so there is one dead cycle between frames.
- Throughput within a frame: 1 beat/cycle when valid and ready are held high.
- frame_done is registered: high in the cycle after the final-beat edge, coincident with IDLE.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Partially transferred beats are not counted, and no frame_done is issued.

## Test plan
- Single requester, FRAME_LEN=4: s0 sends 0x0001..0x0004 with m_ready=1 -> m_data passes 0x0001..0x0004 on consecutive cycles starting one cycle after s0_valid; then frame_done pulses once, frame_cnt=1, busy=0.
- Tie and round-robin: both valid continuously, FRAME_LEN=4 -> grants s0 first, then s1, then s0; m_src sequence 0,1,0; exactly 4 beats per grant; one idle cycle between frames; s1_ready=0 throughout s0's frame.
- Backpressure: m_ready toggles 1,0,1,0 during an s1 frame of FRAME_LEN=4 -> beat count advances only on handshake cycles; frame ends after 4 handshakes (8 cycles); no data duplicated or dropped; s1_ready mirrors m_ready.
- cfg_en: cfg_en=0 with both valid -> stays IDLE with m_valid=0. cfg_en dropped at beat 2 of 4 -> frame completes with 4 beats, then stays IDLE.
- Reset mid-frame: assert rst_n=0 after 2 of 4 beats -> outputs go to reset values without waiting for a clock edge; frame_cnt=0. After release, with both valid, s0 is granted.
- frame_cnt wrap: preload by running 65536 frames (FRAME_LEN=2, single requester) -> frame_cnt reads 0 after the last frame_done.
